fft_wn_mul: RTL
===============

Name: fft_wn_mul

Overview:
- Consumer side of the FFT twiddle interface for the 64-point FFT datapath.
- Drives a stage index to the Wn generator and receives that stage's 16 packed complex twiddles (Q8, 256 = 1.0).
- Multiplies a 16-lane complex data beat by those twiddles through a 2-stage pipeline with valid/ready on both sides.
- Steps through stages 0..STG_NUM-1 once per frame pass.

Parameters:
- DAT_WID, 16, signed width of each data lane (re and im).
- WN_WID, 10, signed width of each twiddle lane; must match the generator.
- WN_LEN, 16, lanes per beat.
- STG_WID, 3, stage index width.
- STG_NUM, 5, stages per pass (indices 0..4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin a pass; honoured only in IDLE.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when high with in_valid_i.
- in_re_i  in  WN_LEN*DAT_WID  packed real lanes; lane k at [k*DAT_WID +: DAT_WID].
- in_im_i  in  WN_LEN*DAT_WID  packed imaginary lanes.
- stage_o  out  STG_WID  stage index presented to the Wn generator.
- wn_re_i  in  WN_LEN*WN_WID  generator real twiddles (combinational from stage_o).
- wn_im_i  in  WN_LEN*WN_WID  generator imaginary twiddles.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- out_re_o  out  WN_LEN*DAT_WID  product real lanes.
- out_im_o  out  WN_LEN*DAT_WID  product imaginary lanes.
- out_stage_o  out  STG_WID  stage tag of the output beat.
- done_o  out  1  one-cycle pulse after the last stage's beat leaves.

Behaviour:
- Reset: FSM = IDLE; stage_o = 0; both pipeline valid bits = 0; out_valid_o = 0; out_re_o/out_im_o = 0; out_stage_o = 0; done_o = 0; in_ready_o = 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start_i; stage_o = 0.
- RUN: each accepted beat increments stage_o. Acceptance of the beat with stage_o = STG_NUM-1 -> DRAIN, and stage_o wraps to 0.
- DRAIN -> IDLE when the output handshake of the tagged last beat occurs. done_o pulses the following cycle.
- start_i in RUN or DRAIN is ignored. in_valid_i in IDLE or DRAIN is ignored; in_ready_o is low in those states.
- Pipeline advance: adv = !out_valid_o || out_ready_i.
- in_ready_o = (state == RUN) && adv && pipeline stage 1 not holding a stalled beat. The whole pipe stalls together.
- Twiddles are sampled on the same edge as the accepted input beat, using the stage_o value in that cycle.
- P1 (registered): per lane, four signed products a*c, b*d, a*d, b*c. Width DAT_WID+WN_WID.
- P2 (registered): re = (a*c - b*d + 128) >>> 8; im = (a*d + b*c + 128) >>> 8. Sums are DAT_WID+WN_WID+1 bits wide; rounding is round-half-up.
- P2 result is clamped to DAT_WID per the optional feature.
- Latency: an accepted beat appears on out_* 2 cycles later with no stall; stalls extend this 1:1.
- out_* hold stable while out_valid_o && !out_ready_i.
- Back-to-back beats sustain 1 beat/cycle while out_ready_i = 1.
- Reset asserted mid-pass: all state is cleared immediately; no done_o pulse.

Optional Feature:
- Macro: FFT_WN_MUL_SAT_EN.
- Defined: each P2 lane saturates to [-2^(DAT_WID-1), 2^(DAT_WID-1)-1].
- Not defined: each P2 lane is truncated to its low DAT_WID bits (two's-complement wrap).

Test Plan:
- Reset, then start_i; stage_o = 0. Beat with all lanes a = 100, b = -50 at stage 0 (wn = 256+j0) -> 2 cycles later out_re = 100, out_im = -50, out_stage_o = 0.
- Stage 1, lane 1, wn = 0-j256, a = 30, b = 7 -> out_re = 7, out_im = -30. Lane 0 (wn = 256) is unchanged.
- Stage 2, lane 1, wn = 181-j181, a = 100, b = 0 -> re = (18100 + 128) >> 8 = 71; im = (-18100 + 128) >>> 8 = -71.
- a = -32768, b = 0 times wn = 0-j256 (im = -(-32768)): with FFT_WN_MUL_SAT_EN -> im = 32767; without -> im = -32768.
- Five consecutive beats with out_ready_i = 1: stage_o runs 0,1,2,3,4 -> out_stage_o follows 2 cycles later, then done_o one-cycle pulse, FSM back in IDLE; start_i during the pass has no effect.
- Hold out_ready_i low for 3 cycles mid-pass -> in_ready_o drops, out_* stay stable, no beats lost or duplicated. Separately, assert rst_n low mid-pass -> all outputs return to reset values.

Source files
------------

// File: rtl/fft_wn_mul.sv
// Twiddle multiplier: presents a stage index to the Wn generator and multiplies 16-lane complex
// beats by that stage's twiddles in a 2-stage pipe. Optional lane saturation: FFT_WN_MUL_SAT_EN.
module fft_wn_mul #(
  parameter int DAT_WID = 16,
  parameter int WN_WID  = 10,
  parameter int WN_LEN  = 16,
  parameter int STG_WID = 3,
  parameter int STG_NUM = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WN_LEN*DAT_WID-1:0] in_re_i,
  input  logic [WN_LEN*DAT_WID-1:0] in_im_i,
  output logic [STG_WID-1:0]        stage_o,
  input  logic [WN_LEN*WN_WID-1:0]  wn_re_i,
  input  logic [WN_LEN*WN_WID-1:0]  wn_im_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WN_LEN*DAT_WID-1:0] out_re_o,
  output logic [WN_LEN*DAT_WID-1:0] out_im_o,
  output logic [STG_WID-1:0]        out_stage_o,
  output logic                      done_o,
  output logic [1:0]                dbg_state_o
);

  localparam int PW = DAT_WID + WN_WID;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(128);
  localparam logic [STG_WID-1:0] LAST_STG = STG_WID'(STG_NUM - 1);
`ifdef FFT_WN_MUL_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DAT_WID - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DAT_WID - 1)));
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [STG_WID-1:0]   stage_q, stage_d;
  logic                 adv, accept, last_fire;

  logic                 v1_q, l1_q;
  logic [STG_WID-1:0]   s1_q;
  logic signed [PW-1:0] ac_q [WN_LEN];
  logic signed [PW-1:0] bd_q [WN_LEN];
  logic signed [PW-1:0] ad_q [WN_LEN];
  logic signed [PW-1:0] bc_q [WN_LEN];
  logic signed [PW-1:0] ac_d [WN_LEN];
  logic signed [PW-1:0] bd_d [WN_LEN];
  logic signed [PW-1:0] ad_d [WN_LEN];
  logic signed [PW-1:0] bc_d [WN_LEN];

  logic                      v2_q, l2_q, done_q;
  logic [STG_WID-1:0]        s2_q;
  logic [WN_LEN*DAT_WID-1:0] re2_q, im2_q, re2_d, im2_d;

  function automatic logic [DAT_WID-1:0] fit(input logic signed [SW-1:0] v);
`ifdef FFT_WN_MUL_SAT_EN
    if (v > MAXV)      return MAXV[DAT_WID-1:0];
    else if (v < MINV) return MINV[DAT_WID-1:0];
    else               return DAT_WID'(v);
`else
    return DAT_WID'(v);
`endif
  endfunction

  // Stage 1 can only be stalled while stage 2 is stalled, so adv alone covers both.
  assign adv        = !v2_q || out_ready_i;
  assign in_ready_o = (state_q == RUN) && adv;
  assign accept     = in_valid_i && in_ready_o;
  assign last_fire  = v2_q && out_ready_i && l2_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        stage_d = '0;
      end
      RUN: if (accept) begin
        if (stage_q == LAST_STG) begin
          state_d = DRAIN;
          stage_d = '0;
        end else begin
          stage_d = stage_q + STG_WID'(1);
        end
      end
      DRAIN: if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < WN_LEN; k++) begin
      ac_d[k] = PW'($signed(in_re_i[k*DAT_WID +: DAT_WID])) * PW'($signed(wn_re_i[k*WN_WID +: WN_WID]));
      bd_d[k] = PW'($signed(in_im_i[k*DAT_WID +: DAT_WID])) * PW'($signed(wn_im_i[k*WN_WID +: WN_WID]));
      ad_d[k] = PW'($signed(in_re_i[k*DAT_WID +: DAT_WID])) * PW'($signed(wn_im_i[k*WN_WID +: WN_WID]));
      bc_d[k] = PW'($signed(in_im_i[k*DAT_WID +: DAT_WID])) * PW'($signed(wn_re_i[k*WN_WID +: WN_WID]));
    end
  end

  always_comb begin
    logic signed [SW-1:0] re_s, im_s;
    re2_d = '0;
    im2_d = '0;
    for (int k = 0; k < WN_LEN; k++) begin
      re_s = SW'(ac_q[k]) - SW'(bd_q[k]) + RND;
      im_s = SW'(ad_q[k]) + SW'(bc_q[k]) + RND;
      re2_d[k*DAT_WID +: DAT_WID] = fit(re_s >>> 8);
      im2_d[k*DAT_WID +: DAT_WID] = fit(im_s >>> 8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      s1_q    <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      s2_q    <= '0;
      re2_q   <= '0;
      im2_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < WN_LEN; k++) begin
        ac_q[k] <= '0;
        bd_q[k] <= '0;
        ad_q[k] <= '0;
        bc_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      done_q  <= last_fire;
      if (adv) begin
        v1_q <= accept;
        if (accept) begin
          s1_q <= stage_q;
          l1_q <= (stage_q == LAST_STG);
          for (int k = 0; k < WN_LEN; k++) begin
            ac_q[k] <= ac_d[k];
            bd_q[k] <= bd_d[k];
            ad_q[k] <= ad_d[k];
            bc_q[k] <= bc_d[k];
          end
        end
        v2_q <= v1_q;
        if (v1_q) begin
          s2_q  <= s1_q;
          l2_q  <= l1_q;
          re2_q <= re2_d;
          im2_q <= im2_d;
        end
      end
    end
  end

  assign stage_o     = stage_q;
  assign out_valid_o = v2_q;
  assign out_re_o    = re2_q;
  assign out_im_o    = im2_q;
  assign out_stage_o = s2_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule
